// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the MIPS run/step/halt controller. The LED and debug
// display logic decodes the same values, so they are kept here in one place.
package cpu_ctrl_pkg;

    // Controller state, exposed on the `state` output.
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } run_state_t;

    // Why the core last stopped, exposed on `halt_cause`.
    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_CMD     = 2'd1,
        HC_BP      = 2'd2,
        HC_TIMEOUT = 2'd3
    } halt_cause_t;

    // Bits needed to count 0 .. cycles-1 (at least one bit).
    function automatic int rst_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. Synchronous clear
// wins over enable. Used for both the enabled-cycle count and the reset hold.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // Count enabled cycles; hold once every bit is set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle MIPS core. Drives the core's
// clock-enable and reset so a host can reset, free-run, single-step or halt
// it, and stops it at a PC breakpoint or when a cycle budget is used up.
//
// Command interface: cmd_reset/cmd_run/cmd_step/cmd_halt are single-cycle
// pulses sampled on the rising edge. There is no ready/acknowledge; a command
// that has no meaning in the current state is simply dropped, and when several
// coincide the order is reset > halt > step > run.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_reset,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_halt,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic [PC_W-1:0]  pc,
    output logic             core_reset,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done
);

    localparam int RST_W = rst_cnt_width(RST_CYCLES);

    run_state_t  state_q, state_d;
    halt_cause_t cause_q, cause_d;
    logic        armed_q;
    logic        done_q, done_d;
    logic [RST_W-1:0] rst_cnt;
    logic        rst_last;
    logic        bp_hit;
    logic        timeout;

    // Cycles spent in RST so far; restarted by every cmd_reset.
    sat_counter #(.CNT_W(RST_W)) u_rst_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_q == ST_RST),
        .clr     (cmd_reset || (state_q != ST_RST)),
        .q       (rst_cnt)
    );

    // Enabled core cycles since the core was last held in reset.
    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cpu_en),
        .clr     (state_q == ST_RST),
        .q       (cycle_cnt)
    );

    assign rst_last = (rst_cnt == RST_W'(RST_CYCLES - 1));

    // The breakpoint is disarmed for the first RUN cycle so resuming from a
    // breakpoint executes the instruction it stopped on.
    assign bp_hit  = bp_en && (pc == bp_addr) && armed_q;
    assign timeout = (max_cycles != '0) && (cycle_cnt >= max_cycles);

    // Next state, halt cause and the combinational core enable.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cpu_en  = 1'b0;
        done_d  = 1'b0;
        if (cmd_reset) begin
            // The core is about to be reset, so nothing executes this cycle.
            state_d = ST_RST;
            cause_d = HC_NONE;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (rst_last) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // A coincident halt outranks step/run and leaves us idle.
                    if (!cmd_halt) begin
                        if (cmd_step) begin
                            state_d = ST_STEP;
                            cause_d = HC_NONE;
                        end else if (cmd_run) begin
                            state_d = ST_RUN;
                            cause_d = HC_NONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (cmd_halt) begin
                        state_d = ST_IDLE;
                        cause_d = HC_CMD;
                    end else if (bp_hit) begin
                        state_d = ST_IDLE;
                        cause_d = HC_BP;
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                        cause_d = HC_TIMEOUT;
                    end else begin
                        cpu_en = 1'b1;
                    end
                end
                ST_STEP: begin
                    state_d = ST_IDLE;
                    if (timeout) begin
                        cause_d = HC_TIMEOUT;
                    end else begin
                        cpu_en  = 1'b1;
                        cause_d = HC_CMD;
                    end
                end
                default: begin
                    state_d = ST_RST;
                end
            endcase
        end
        done_d = ((state_q == ST_RUN) || (state_q == ST_STEP)) && (state_d == ST_IDLE);
    end

    // State register plus the arm flag and the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RST;
            cause_q <= HC_NONE;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            armed_q <= (state_q == ST_RUN);
            done_q  <= done_d;
        end
    end

    assign core_reset = (state_q == ST_RST);
    assign state      = state_q;
    assign halt_cause = cause_q;
    assign done       = done_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt controller for the single-cycle MIPS core. It drives the core's clock-enable and core-reset, so the core can be reset, free-run, single-stepped or halted from a host, a debug panel or a bench. It stops the core at a PC breakpoint or after a programmable cycle budget. It sits between `mips_top` and whatever issues commands, and replaces hand-written run loops with one reusable sequencer.

## Interface
Parameters:
- `PC_W`, 32, width of the PC compared for breakpoints
- `CNT_W`, 16, width of the cycle counter and budget
- `RST_CYCLES`, 2, cycles `core_reset` stays high per reset sequence (≥1)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_reset`  in  1  pulse: restart reset sequence
- `cmd_run`  in  1  pulse: free-run
- `cmd_step`  in  1  pulse: execute exactly one instruction
- `cmd_halt`  in  1  pulse: stop
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  PC_W  breakpoint PC
- `max_cycles`  in  CNT_W  cycle budget; 0 = unlimited
- `pc`  in  PC_W  core's current PC (address of instruction about to execute)
- `core_reset`  out  1  active-high reset to core
- `cpu_en`  out  1  core clock-enable (combinational)
- `state`  out  2  0 RST, 1 IDLE, 2 RUN, 3 STEP
- `halt_cause`  out  2  0 none, 1 cmd, 2 breakpoint, 3 timeout
- `cycle_cnt`  out  CNT_W  enabled cycles since last core reset
- `done`  out  1  one-cycle pulse on every RUN/STEP→IDLE transition

## Operation
- Reset values: `state`=RST, `core_reset`=1, `cpu_en`=0, `halt_cause`=0, `cycle_cnt`=0, `done`=0.
- RST: `core_reset`=1 for RST_CYCLES cycles, then IDLE. `cycle_cnt` is cleared. Run, step and halt are ignored in RST.
- IDLE: `cpu_en`=0.
  - `cmd_run` → RUN.
  - `cmd_step` → STEP.
  - `cmd_halt` has no effect.
- RUN: `cpu_en`=1 unless one of these stop terms is true:
  - `cmd_halt`: go to IDLE, cause=1.
  - bp_hit = `bp_en` && `pc`==`bp_addr` && armed: go to IDLE, cause=2.
  - timeout = `max_cycles`≠0 && `cycle_cnt`≥`max_cycles`: go to IDLE, cause=3.
  - In each case `cpu_en`=0 that same cycle, so the instruction at the stop PC is not executed.
- Breakpoint arming: `armed` is cleared on RUN entry and set after the first RUN cycle. Resuming from a breakpoint therefore executes that instruction.
- STEP: `cpu_en`=1 for exactly one cycle, then IDLE with cause=1.
  - Breakpoints are ignored in STEP.
  - A timeout that is already reached blocks the step: `cpu_en`=0, go to IDLE, cause=3.
- Priority when commands coincide: `cmd_reset` > `cmd_halt` > `cmd_step` > `cmd_run`. Among stop terms: halt > breakpoint > timeout.
- `cmd_reset` is honoured in any state, including mid-RST, which restarts the count. It clears `halt_cause`.
- `cmd_run` or `cmd_step` accepted from IDLE clears `halt_cause` to 0.
- `cycle_cnt` increments on every cycle with `cpu_en`=1 and saturates at all-ones.

## Timing
- `cpu_en` is combinational from registered `state`, `armed`, `cycle_cnt` and the live inputs `pc`, `cmd_halt`, `bp_*`, `max_cycles`. `pc` must be a registered core output, so there is no loop.
- Command accepted at edge N: `cpu_en` is first high in the cycle after edge N.
- `done`, `halt_cause` and `state` update on the edge that ends the last enabled (or stopped) cycle, so `done` is high for the cycle following it.
- `core_reset` is high for exactly RST_CYCLES cycles after `reset_n` deassertion or after the `cmd_reset` edge.
- Asynchronous `reset_n` assertion mid-run forces `cpu_en`=0 immediately, without waiting for a clock edge.

## Structure
- Package `cpu_ctrl_pkg`: state encodings (ST_RST, ST_IDLE, ST_RUN, ST_STEP) and halt-cause encodings (HC_NONE, HC_CMD, HC_BP, HC_TIMEOUT). The LED/debug display logic reuses them.
- Single module. A small `sat_counter` sub-module (CNT_W, en, clr, q) is natural and is also used for the reset-hold count.

## Test plan
- Reset with RST_CYCLES=2 → `core_reset` high 2 cycles, then `state`=IDLE, `cpu_en`=0, `cycle_cnt`=0.
- `cmd_run`, `max_cycles`=0, `bp_en`=1, `bp_addr`=0x3F, `pc` advancing 1 per enabled cycle from 0 → `cpu_en` low on the cycle `pc`=0x3F. Then `cause`=2, `cycle_cnt`=63, one `done` pulse. A second `cmd_run` executes 0x3F and continues.
- `max_cycles`=500, no breakpoint, `cmd_run` → exactly 500 enabled cycles, then `cause`=3. A subsequent `cmd_step` produces no enabled cycle, `cause`=3, `done` pulse.
- Three `cmd_step` pulses from IDLE → three single enabled cycles, `cycle_cnt`=3, three `done` pulses. A step at `pc`==`bp_addr` still executes.
- `cmd_halt` and `cmd_step` in the same cycle while in RUN → `cpu_en`=0 that cycle, IDLE, `cause`=1. `cmd_reset` with `cmd_run` together → RST entered, run ignored.
- `reset_n` pulsed low mid-RUN at `cycle_cnt`=40 → `cpu_en` drops asynchronously and all outputs return to their reset values.
